// File: rtl/usb_cdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_cdc_pkg
//  Description : Shared definitions for the bulk endpoint scheduler.
//                Contains the scheduler FSM state encoding, the DATA0/DATA1
//                toggle constants and the USB endpoint-number width.
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_cdc_pkg;

    // Width of a USB endpoint number as carried by the token.
    localparam int c_ENDP_W = 4;

    // Scheduler FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE     = 2'd0;
    localparam state_t c_ST_IN_XFER  = 2'd1;
    localparam state_t c_ST_OUT_XFER = 2'd2;
    localparam state_t c_ST_OUT_DROP = 2'd3;

    // Data toggle values.
    localparam logic c_TOG_DATA0 = 1'b0;
    localparam logic c_TOG_DATA1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/toggle_bank.sv
`default_nettype none
// ============================================================================
//  Module      : toggle_bank
//  Description : Per-slot DATA0/DATA1 toggle storage.
//                Ports: clk, rst (sync, active-high), i_flip/i_flip_idx flip
//                one slot, i_clr_mask forces slots back to DATA0 (wins over a
//                flip), i_rd_idx/o_rd read one slot combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module toggle_bank
    import usb_cdc_pkg::*;
#(
    parameter int NUM_ENDP = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_flip,
    input  logic [2:0]          i_flip_idx,
    input  logic [NUM_ENDP-1:0] i_clr_mask,
    input  logic [2:0]          i_rd_idx,
    output logic                o_rd
);

    logic [NUM_ENDP-1:0] r_tog;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tog <= {NUM_ENDP{c_TOG_DATA0}};
        end else begin
            for (int k = 0; k < NUM_ENDP; k++) begin
                if (i_clr_mask[k]) begin
                    r_tog[k] <= c_TOG_DATA0;
                end else if (i_flip && (i_flip_idx == 3'(k))) begin
                    r_tog[k] <= (r_tog[k] == c_TOG_DATA0) ? c_TOG_DATA1 : c_TOG_DATA0;
                end
            end
        end
    end

    always_comb begin
        o_rd = c_TOG_DATA0;
        for (int k = 0; k < NUM_ENDP; k++) begin
            if (i_rd_idx == 3'(k)) begin
                o_rd = r_tog[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bulk_endp_sched.sv
`default_nettype none
// ============================================================================
//  Module      : bulk_endp_sched
//  Description : Routes SIE IN/OUT transactions to NUM_ENDP bulk endpoint
//                slots (USB endpoints EP_BASE..EP_BASE+NUM_ENDP-1) and keeps
//                the per-slot data toggles.
//                SIE side : endp_i, in_req_i, in_ready_i, in_data_ack_i,
//                           in_data_o/in_valid_o/in_toggle_o, out_* strobes,
//                           out_nak_o, stall_o.
//                Slot side: ep_in_* / ep_out_* routed to the selected slot,
//                           ep_in_data_i/ep_in_valid_i/ep_out_nak_i/ep_halt_i.
//                Optional : define BULK_SCHED_STALL_EN to honour ep_halt_i.
//  Revision    : 1.0 - initial release
// ============================================================================
module bulk_endp_sched
    import usb_cdc_pkg::*;
#(
    parameter int NUM_ENDP = 2,
    parameter int EP_BASE  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [c_ENDP_W-1:0]   endp_i,
    input  logic                  in_req_i,
    input  logic                  in_ready_i,
    input  logic                  in_data_ack_i,
    output logic [7:0]            in_data_o,
    output logic                  in_valid_o,
    output logic                  in_toggle_o,
    input  logic [7:0]            out_data_i,
    input  logic                  out_valid_i,
    input  logic                  out_err_i,
    input  logic                  out_ready_i,
    input  logic                  out_toggle_i,
    output logic                  out_nak_o,
    output logic                  stall_o,
    output logic [NUM_ENDP-1:0]   ep_in_req_o,
    output logic [NUM_ENDP-1:0]   ep_in_ready_o,
    output logic [NUM_ENDP-1:0]   ep_in_data_ack_o,
    input  logic [8*NUM_ENDP-1:0] ep_in_data_i,
    input  logic [NUM_ENDP-1:0]   ep_in_valid_i,
    output logic [NUM_ENDP-1:0]   ep_out_valid_o,
    output logic [NUM_ENDP-1:0]   ep_out_err_o,
    output logic [NUM_ENDP-1:0]   ep_out_ready_o,
    input  logic [NUM_ENDP-1:0]   ep_out_nak_i,
    input  logic [NUM_ENDP-1:0]   ep_halt_i
);

    localparam logic [4:0] c_EP_LO = 5'(EP_BASE);
    localparam logic [4:0] c_EP_HI = 5'(EP_BASE + NUM_ENDP);

    state_t     r_state;
    logic [2:0] r_sel;
    logic       r_mapped;
    logic       r_in_req_d;
    logic       r_valid_seen;
    logic       r_nak_seen;

    logic [4:0]          w_endp_ext, w_endp_off;
    logic                w_dec_mapped, w_idle, w_in_rise, w_in_start, w_out_start;
    logic [2:0]          w_sel;
    logic                w_mapped, w_in_phase, w_out_phase, w_drop_phase, w_active;
    logic                w_fin, w_tog_rd, w_tog_sel, w_mismatch, w_slot_nak;
    logic                w_drop_now, w_zlp_drop, w_drop_end, w_flip, w_halt;
    logic [NUM_ENDP-1:0] w_hit, w_route, w_clr;
    logic [7:0]          w_in_data;
    logic                w_in_valid;

    // The byte bus reaches the slots directly; only the strobes pass here.
    logic w_unused_out_data;
    assign w_unused_out_data = |out_data_i;

    assign w_endp_ext   = {1'b0, endp_i};
    assign w_endp_off   = w_endp_ext - c_EP_LO;
    assign w_dec_mapped = (w_endp_ext >= c_EP_LO) && (w_endp_ext < c_EP_HI);

    assign w_idle      = (r_state == c_ST_IDLE);
    assign w_in_rise   = in_req_i & ~r_in_req_d;
    assign w_in_start  = w_idle & w_in_rise;
    // IN wins when a token rise and an OUT strobe coincide.
    assign w_out_start = w_idle & ~w_in_rise & (out_valid_i | out_ready_i);

    // While idle, the first strobe is routed straight from endp_i so the
    // opening cycle of a transaction is not lost to the selection latch.
    assign w_sel    = w_idle ? w_endp_off[2:0] : r_sel;
    assign w_mapped = w_idle ? w_dec_mapped    : r_mapped;

    assign w_in_phase   = w_in_start  | (r_state == c_ST_IN_XFER);
    assign w_out_phase  = w_out_start | (r_state == c_ST_OUT_XFER);
    assign w_drop_phase = (r_state == c_ST_OUT_DROP);
    assign w_active     = w_in_phase | w_out_phase | w_drop_phase;

    // Packet end: ready with no data byte, or ready with an error abort.
    assign w_fin = out_ready_i & (~out_valid_i | out_err_i);

    always_comb begin
        w_hit = '0;
        for (int k = 0; k < NUM_ENDP; k++) begin
            w_hit[k] = w_mapped && (w_sel == 3'(k));
        end
    end

`ifdef BULK_SCHED_STALL_EN
    logic [NUM_ENDP-1:0] r_halt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_halt_d <= '0;
        end else begin
            r_halt_d <= ep_halt_i;
        end
    end

    assign w_halt  = |(ep_halt_i & w_hit);
    // A slot leaving halt restarts its data sequence at DATA0.
    assign w_clr   = r_halt_d & ~ep_halt_i;
    assign stall_o = ~rst_i & w_active & w_halt;
`else
    logic w_unused_halt;
    assign w_unused_halt = |ep_halt_i;
    assign w_halt        = 1'b0;
    assign w_clr         = '0;
    assign stall_o       = 1'b0;
`endif

    assign w_route    = w_hit & {NUM_ENDP{~rst_i & ~w_halt}};
    assign w_tog_sel  = w_mapped & w_tog_rd;
    assign w_mismatch = (out_toggle_i != w_tog_sel);
    assign w_slot_nak = |(ep_out_nak_i & w_hit);

    // Wrong toggle on the first data byte: the host is resending a packet we
    // already took, so ACK it but keep it away from the slot.
    assign w_drop_now = w_out_phase & out_valid_i & ~r_valid_seen & w_mismatch
                        & w_mapped & ~w_halt;
    // A zero-length packet carries no byte, so its toggle is judged at the end.
    assign w_zlp_drop = w_out_phase & w_fin & ~out_valid_i & ~out_err_i & ~r_valid_seen
                        & w_mismatch & w_mapped & ~w_halt;
    assign w_drop_end = ((w_drop_phase | w_drop_now) & w_fin) | w_zlp_drop;

    assign w_flip = ~rst_i & w_mapped & ~w_halt &
                    ((w_in_phase & in_data_ack_i & out_ready_i) |
                     (w_out_phase & out_ready_i & ~out_valid_i & ~out_err_i & ~w_zlp_drop
                      & ~(w_slot_nak | r_nak_seen)));

    toggle_bank #(
        .NUM_ENDP (NUM_ENDP)
    ) u_toggle_bank (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_flip     (w_flip),
        .i_flip_idx (w_sel),
        .i_clr_mask (w_clr),
        .i_rd_idx   (w_sel),
        .o_rd       (w_tog_rd)
    );

    always_comb begin
        w_in_data  = '0;
        w_in_valid = 1'b0;
        for (int k = 0; k < NUM_ENDP; k++) begin
            if (w_route[k]) begin
                w_in_data  = ep_in_data_i[8*k +: 8];
                w_in_valid = ep_in_valid_i[k];
            end
        end
    end

    assign in_data_o        = w_in_phase ? w_in_data : 8'h00;
    assign in_valid_o       = w_in_phase & w_in_valid;
    assign in_toggle_o      = ~rst_i & w_in_phase & w_tog_sel;
    assign ep_in_req_o      = w_route & {NUM_ENDP{in_req_i & w_in_phase}};
    assign ep_in_ready_o    = w_route & {NUM_ENDP{in_ready_i & w_in_phase}};
    assign ep_in_data_ack_o = w_route & {NUM_ENDP{in_data_ack_i & w_in_phase}};

    assign ep_out_valid_o = w_route & {NUM_ENDP{out_valid_i & w_out_phase & ~w_drop_now}};
    assign ep_out_ready_o = w_route & {NUM_ENDP{(out_ready_i & w_out_phase & ~w_drop_now
                                                 & ~w_zlp_drop) | w_drop_end}};
    assign ep_out_err_o   = w_route & {NUM_ENDP{(out_err_i & w_out_phase & ~w_drop_now
                                                 & ~w_zlp_drop) | w_drop_end}};

    assign out_nak_o = ~rst_i & ((w_active & ~w_mapped) |
                                 (w_out_phase & w_slot_nak & ~w_drop_now & ~w_zlp_drop));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= c_ST_IDLE;
            r_sel        <= 3'd0;
            r_mapped     <= 1'b0;
            r_in_req_d   <= 1'b0;
            r_valid_seen <= 1'b0;
            r_nak_seen   <= 1'b0;
        end else begin
            r_in_req_d <= in_req_i;
            if (w_in_start) begin
                r_state  <= c_ST_IN_XFER;
                r_sel    <= w_sel;
                r_mapped <= w_mapped;
            end else if (w_out_phase) begin
                r_sel    <= w_sel;
                r_mapped <= w_mapped;
                if (w_fin) begin
                    r_state      <= c_ST_IDLE;
                    r_valid_seen <= 1'b0;
                    r_nak_seen   <= 1'b0;
                end else begin
                    r_state      <= w_drop_now ? c_ST_OUT_DROP : c_ST_OUT_XFER;
                    r_valid_seen <= r_valid_seen | out_valid_i;
                    r_nak_seen   <= r_nak_seen | w_slot_nak;
                end
            end else if (r_state == c_ST_IN_XFER) begin
                if (!in_req_i) begin
                    r_state <= c_ST_IDLE;
                end
            end else if (w_drop_phase && w_fin) begin
                r_state      <= c_ST_IDLE;
                r_valid_seen <= 1'b0;
                r_nak_seen   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bulk_endp_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bulk_endp_sched
//  Description : Self-checking bench for bulk_endp_sched (NUM_ENDP=2,
//                EP_BASE=1). Directed scenarios followed by random IN/OUT
//                transactions checked against a transaction-level model of
//                the per-endpoint data toggles and routing rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bulk_endp_sched;

    localparam int NE   = 2;
    localparam int BASE = 1;
    localparam int DW   = 8 * NE;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [3:0]    endp_i;
    logic          in_req_i, in_ready_i, in_data_ack_i;
    logic [7:0]    in_data_o;
    logic          in_valid_o, in_toggle_o;
    logic [7:0]    out_data_i;
    logic          out_valid_i, out_err_i, out_ready_i, out_toggle_i;
    logic          out_nak_o, stall_o;
    logic [NE-1:0] ep_in_req_o, ep_in_ready_o, ep_in_data_ack_o;
    logic [DW-1:0] ep_in_data_i;
    logic [NE-1:0] ep_in_valid_i;
    logic [NE-1:0] ep_out_valid_o, ep_out_err_o, ep_out_ready_o;
    logic [NE-1:0] ep_out_nak_i, ep_halt_i;

    always #5 clk = ~clk;

    bulk_endp_sched #(.NUM_ENDP(NE), .EP_BASE(BASE)) dut (
        .clk_i(clk), .rst_i(rst_i), .endp_i(endp_i),
        .in_req_i(in_req_i), .in_ready_i(in_ready_i), .in_data_ack_i(in_data_ack_i),
        .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_toggle_o(in_toggle_o),
        .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_err_i(out_err_i),
        .out_ready_i(out_ready_i), .out_toggle_i(out_toggle_i),
        .out_nak_o(out_nak_o), .stall_o(stall_o),
        .ep_in_req_o(ep_in_req_o), .ep_in_ready_o(ep_in_ready_o),
        .ep_in_data_ack_o(ep_in_data_ack_o), .ep_in_data_i(ep_in_data_i),
        .ep_in_valid_i(ep_in_valid_i), .ep_out_valid_o(ep_out_valid_o),
        .ep_out_err_o(ep_out_err_o), .ep_out_ready_o(ep_out_ready_o),
        .ep_out_nak_i(ep_out_nak_i), .ep_halt_i(ep_halt_i)
    );

    int            checks = 0;
    int            errors = 0;
    logic [NE-1:0] tog_m;   // expected toggle of each endpoint slot

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mapped(input int e);
        return (e >= BASE) && (e < BASE + NE);
    endfunction

    function automatic logic [NE-1:0] onehot(input int e);
        logic [NE-1:0] v = '0;
        if (is_mapped(e)) v[e - BASE] = 1'b1;
        return v;
    endfunction

    task automatic idle_inputs();
        in_req_i = 0; in_ready_i = 0; in_data_ack_i = 0;
        out_valid_i = 0; out_err_i = 0; out_ready_i = 0; out_toggle_i = 0;
        out_data_i = 8'h00; ep_out_nak_i = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 32'({in_data_o, in_valid_o, in_toggle_o, out_nak_o, stall_o,
                      ep_in_req_o, ep_in_ready_o, ep_in_data_ack_o,
                      ep_out_valid_o, ep_out_err_o, ep_out_ready_o}), 32'd0);
    endtask

    task automatic do_in(input int e, input bit ack);
        int            s = e - BASE;
        bit            m = is_mapped(e);
        logic [NE-1:0] h = onehot(e);
        logic          exp_v = 1'b0;
        logic [7:0]    exp_d = 8'h00;
        logic          exp_t = 1'b0;
        @(negedge clk);
        endp_i = 4'(e); in_req_i = 1;
        ep_in_valid_i = NE'($urandom); ep_in_data_i = DW'($urandom);
        if (m) begin
            exp_v = ep_in_valid_i[s]; exp_d = ep_in_data_i[8*s +: 8]; exp_t = tog_m[s];
        end
        #1;
        chk("in_req_route", 32'(ep_in_req_o), 32'(h));
        chk("in_valid", 32'(in_valid_o), 32'(exp_v));
        chk("in_data", 32'(in_data_o), 32'(exp_d));
        chk("in_toggle", 32'(in_toggle_o), 32'(exp_t));
        chk("in_out_nak", 32'(out_nak_o), 32'(!m));
        chk("in_stall", 32'(stall_o), 32'd0);
        chk("in_no_out_valid", 32'(ep_out_valid_o), 32'd0);
        @(negedge clk);
        in_ready_i = 1;
        #1 chk("in_ready_route", 32'(ep_in_ready_o), 32'(h));
        @(negedge clk);
        in_ready_i = 0;
        if (ack) begin
            in_data_ack_i = 1; out_ready_i = 1;
            #1;
            chk("in_ack_route", 32'(ep_in_data_ack_o), 32'(h));
            chk("in_ack_no_out_ready", 32'(ep_out_ready_o), 32'd0);
            @(negedge clk);
            in_data_ack_i = 0; out_ready_i = 0;
            if (m) tog_m[s] = ~tog_m[s];
            #1 chk("in_toggle_after_ack", 32'(in_toggle_o), m ? 32'(tog_m[s]) : 32'd0);
        end
        @(negedge clk);
        in_req_i = 0;
        #1 chk("in_req_end", 32'(ep_in_req_o), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_out(input int e, input bit ptog, input int nb, input bit nak, input bit err);
        int            s = e - BASE;
        bit            m = is_mapped(e);
        logic [NE-1:0] h = onehot(e);
        bit            drop = 1'b0;
        logic [NE-1:0] nakv = NE'($urandom);
        logic          exp_nak;
        if (m) begin
            drop    = (ptog != tog_m[s]);
            nakv[s] = nak;
        end
        exp_nak = !m ? 1'b1 : (drop ? 1'b0 : nak);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            endp_i = 4'(e); out_valid_i = 1; out_ready_i = 1; out_err_i = 0;
            out_toggle_i = ptog; out_data_i = 8'($urandom); ep_out_nak_i = nakv;
            #1;
            chk("out_valid_route", 32'(ep_out_valid_o), (m && !drop) ? 32'(h) : 32'd0);
            chk("out_ready_byte", 32'(ep_out_ready_o), (m && !drop) ? 32'(h) : 32'd0);
            chk("out_nak", 32'(out_nak_o), 32'(exp_nak));
            chk("out_err_mid", 32'(ep_out_err_o), 32'd0);
        end
        @(negedge clk);
        out_valid_i = 0; out_ready_i = 1; out_err_i = err;
        #1;
        chk("out_end_ready", 32'(ep_out_ready_o), 32'(h));
        chk("out_end_err", 32'(ep_out_err_o), (drop || err) ? 32'(h) : 32'd0);
        chk("out_end_nak", 32'(out_nak_o), 32'(exp_nak));
        @(negedge clk);
        idle_inputs();
        if (m && !drop && !nak && !err) tog_m[s] = ~tog_m[s];
        #1;
        chk("out_err_single", 32'(ep_out_err_o), 32'd0);
        chk("out_idle_nak", 32'(out_nak_o), 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst_i = 1; endp_i = 4'd0; ep_in_data_i = '0; ep_in_valid_i = '0; ep_halt_i = '0;
        tog_m = '0;
        repeat (3) @(negedge clk);
        // Activity during reset must not leak to any output.
        in_req_i = 1; endp_i = 4'd1; out_valid_i = 1; out_ready_i = 1; ep_in_valid_i = '1;
        #1 chk_all_zero("reset_hold");
        @(negedge clk);
        idle_inputs(); rst_i = 0;
        #1 chk_all_zero("after_reset");

        // Endpoint 2 IN with ACK, then next IN shows DATA1.
        do_in(2, 1'b1);
        do_in(2, 1'b0);
        // IN without ACK leaves the toggle alone.
        do_in(2, 1'b0);
        // Endpoint 1 OUT with wrong toggle: dropped, toggle stays DATA0.
        do_out(1, 1'b1, 2, 1'b0, 1'b0);
        do_in(1, 1'b0);
        // Unmapped endpoint.
        do_in(5, 1'b1);
        do_out(5, 1'b0, 2, 1'b0, 1'b0);
        do_out(0, 1'b1, 1, 1'b0, 1'b0);

        // Token rise and OUT strobe together: IN wins.
        @(negedge clk);
        endp_i = 4'd1; in_req_i = 1; out_valid_i = 1; out_ready_i = 1;
        #1;
        chk("prio_in_req", 32'(ep_in_req_o), 32'd1);
        chk("prio_no_out_valid", 32'(ep_out_valid_o), 32'd0);
        chk("prio_no_out_ready", 32'(ep_out_ready_o), 32'd0);
        @(negedge clk);
        out_valid_i = 0; out_ready_i = 0;
        @(negedge clk);
        in_req_i = 0;
        @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            int r    = int'($urandom_range(0, 9));
            int e    = (r < 8) ? (BASE + r % NE) : ((r == 8) ? 0 : 5);
            bit ptog = $urandom_range(0, 3) == 0;
`ifndef BULK_SCHED_STALL_EN
            ep_halt_i = NE'($urandom);
`endif
            if (is_mapped(e)) ptog = ptog ^ tog_m[e - BASE];
            if ($urandom_range(0, 1) == 0)
                do_in(e, $urandom_range(0, 3) != 0);
            else
                do_out(e, ptog, int'($urandom_range(1, 3)),
                       $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
        end

`ifdef BULK_SCHED_STALL_EN
        ep_halt_i = '0;
        if (tog_m[0] == 1'b0) do_out(1, 1'b0, 1, 1'b0, 1'b0);
        @(negedge clk);
        ep_halt_i = NE'(1); endp_i = 4'd1; out_valid_i = 1; out_ready_i = 1;
        out_toggle_i = tog_m[0];
        #1;
        chk("stall_asserted", 32'(stall_o), 32'd1);
        chk("stall_no_out_valid", 32'(ep_out_valid_o), 32'd0);
        chk("stall_no_out_ready", 32'(ep_out_ready_o), 32'd0);
        @(negedge clk);
        out_valid_i = 0; out_ready_i = 1;
        #1;
        chk("stall_end", 32'(stall_o), 32'd1);
        chk("stall_end_no_ready", 32'(ep_out_ready_o), 32'd0);
        chk("stall_end_no_err", 32'(ep_out_err_o), 32'd0);
        @(negedge clk);
        out_ready_i = 0;
        @(negedge clk);
        ep_halt_i = '0; tog_m[0] = 1'b0;
        do_in(1, 1'b0);
`endif

        // Reset in the middle of an IN transaction.
        if (tog_m == '0) do_in(2, 1'b1);
        @(negedge clk);
        endp_i = 4'd2; in_req_i = 1;
        @(negedge clk);
        in_ready_i = 1;
        @(negedge clk);
        rst_i = 1;
        #1 chk_all_zero("reset_mid_in");
        @(negedge clk);
        rst_i = 0; idle_inputs(); tog_m = '0;
        #1 chk_all_zero("after_mid_reset");
        do_in(1, 1'b0);
        do_in(2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/bulk_endp_sched.md
BULK_ENDP_SCHED -- requirements
Module: bulk_endp_sched
Interface
REQ-001 SHALL have parameter NUM_ENDP, default 2, number of bulk endpoint slots (1..8).
REQ-002 SHALL have parameter EP_BASE, default 1, USB endpoint number of slot 0.
REQ-003 clk_i  input  1  clock, 12MHz*BIT_SAMPLES; one clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high; top ORs usb_reset_i into it.
REQ-005 endp_i  input  4  endpoint number of current token, valid from in_req_i rise or first out_* strobe.
REQ-006 in_req_i  input  1  SIE IN transaction request, high for the whole IN transaction.
REQ-007 in_ready_i  input  1  SIE consumes in_data_o; single-cycle pulse.
REQ-008 in_data_ack_i  input  1  with out_ready_i, host ACK received for IN data.
REQ-009 in_data_o  output  8  IN byte muxed from the selected slot.
REQ-010 in_valid_o  output  1  IN byte valid, muxed from the selected slot.
REQ-011 in_toggle_o  output  1  DATA0(0)/DATA1(1) for the current IN packet.
REQ-012 out_data_i  input  8  OUT byte, broadcast unregistered to all slots.
REQ-013 out_valid_i  input  1  OUT byte valid.
REQ-014 out_err_i  input  1  with out_ready_i, abort the current OUT packet.
REQ-015 out_ready_i  input  1  SIE strobe, single-cycle.
REQ-016 out_toggle_i  input  1  toggle of received OUT DATA PID.
REQ-017 out_nak_o  output  1  NAK for current OUT transaction.
REQ-018 stall_o  output  1  STALL handshake for the current transaction.
REQ-019 ep_in_req_o  output  NUM_ENDP  in_req_i routed to the selected slot only.
REQ-020 ep_in_ready_o  output  NUM_ENDP  in_ready_i routed to the selected slot only.
REQ-021 ep_in_data_ack_o  output  NUM_ENDP  in_data_ack_i routed to the selected slot only.
REQ-022 ep_in_data_i  input  8*NUM_ENDP  per-slot IN bytes, slot k at bits [8k+7:8k].
REQ-023 ep_in_valid_i  input  NUM_ENDP  per-slot IN valid.
REQ-024 ep_out_valid_o / ep_out_err_o / ep_out_ready_o  output  NUM_ENDP each  SIE OUT strobes routed to the selected slot only.
REQ-025 ep_out_nak_i  input  NUM_ENDP  per-slot OUT FIFO NAK.
REQ-026 ep_halt_i  input  NUM_ENDP  per-slot halt request (used only with BULK_SCHED_STALL_EN).
Function
REQ-027 SHALL implement FSM IDLE, IN_XFER, OUT_XFER, OUT_DROP; IDLE->IN_XFER on in_req_i rise; IDLE->OUT_XFER on first out_valid_i or out_ready_i.
REQ-028 SHALL latch slot sel = endp_i-EP_BASE on leaving IDLE; unmapped endp_i (outside EP_BASE..EP_BASE+NUM_ENDP-1) SHALL give in_valid_o=0, out_nak_o=1, no ep_* strobes.
REQ-029 Routing SHALL be combinational from the latched sel: zero added latency, all non-selected ep_* outputs held 0.
REQ-030 IN_XFER->IDLE on in_req_i fall; on in_data_ack_i&out_ready_i, toggle[sel] SHALL flip on the next cycle; IN end without ACK (timeout) SHALL leave toggle unchanged.
REQ-031 In OUT_XFER, out_toggle_i!=toggle[sel] at the first out_valid_i SHALL enter OUT_DROP: packet ACKed (out_nak_o=0), ep_out_valid_o suppressed, ep_out_err_o[sel] pulsed once at packet end, toggle unchanged.
REQ-032 OUT end (out_ready_i with out_valid_i=0, out_err_i=0) SHALL flip toggle[sel] only if not dropped, not NAKed, no error; state SHALL return to IDLE.
REQ-033 out_nak_o SHALL equal ep_out_nak_i[sel] while in OUT_XFER, 1 for unmapped slots, 0 otherwise.
REQ-034 A simultaneous in_req_i rise and out strobe in IDLE SHALL give IN priority.
Reset
REQ-035 rst_i SHALL force IDLE, sel=0, all toggles=0 (DATA0), all outputs 0; reset mid-transaction SHALL abort with no ep_* strobe in the reset cycle.
Configuration
REQ-036 With BULK_SCHED_STALL_EN defined, ep_halt_i[sel]=1 SHALL assert stall_o, block all ep_* strobes, and clear toggle[sel] to 0 when halt deasserts.
REQ-037 Without BULK_SCHED_STALL_EN, ep_halt_i SHALL be ignored and stall_o tied 0.
Structure
REQ-038 FSM state enum, toggle-bit constants and endpoint-number width SHALL live in shared package usb_cdc_pkg.
REQ-039 Per-slot toggle storage (flip/clear/read by index) SHALL be sub-module toggle_bank.
Verification
REQ-040 NUM_ENDP=2: endp_i=2, IN with ACK -> only slot 1 strobed, in_toggle_o 0 then 1 on the next IN.
REQ-041 OUT to endp_i=1 with out_toggle_i=1 while toggle=0 -> no ep_out_valid_o, ep_out_err_o[0] single pulse, toggle stays 0.
REQ-042 endp_i=5 IN and OUT -> in_valid_o=0, out_nak_o=1, all ep_* 0.
REQ-043 STALL_EN, ep_halt_i=2'b01, OUT to endp 1 -> stall_o=1, toggle[0]=0 after halt release; rst_i mid-IN -> IDLE, all outputs 0.
